// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - three-port SRAM arbiter and command sequencer with self-timed read-valid strobe
// Build option: define SRAM_ARB_RR_EN for round-robin arbitration; fixed priority (port 0 > 2 > 1) otherwise.
module sram_arbiter #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              sd_req,
    input  logic [ADDR_W-1:0] sd_addr,
    input  logic [DATA_W-1:0] sd_data,
    output logic              sd_gnt,

    input  logic              wb_req,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_gnt,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,

    output logic              sram_enable,
    output logic              sram_mode,
    output logic              sram_addr_calc_mode,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_sdram_data,
    output logic [DATA_W-1:0] sram_wb_data,
    input  logic [DATA_W-1:0] sram_out_data,

    output logic              busy
);

    localparam logic [1:0] PORT_SD = 2'd0;
    localparam logic [1:0] PORT_WB = 2'd1;
    localparam logic [1:0] PORT_RD = 2'd2;

    logic [2:0]        req;
    logic [2:0]        gnt;
    logic              xfer;
    logic [1:0]        gnt_idx;

    logic [1:0]        last_q,     last_d;
    logic              enable_q,   enable_d;
    logic              mode_q,     mode_d;
    logic              calc_q,     calc_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic [DATA_W-1:0] sd_data_q,  sd_data_d;
    logic [DATA_W-1:0] wb_data_q,  wb_data_d;
    logic [1:0]        rd_pipe_q,  rd_pipe_d;

    assign req = {rd_req, wb_req, sd_req};

    // Grant is purely combinational so a requester can transfer in the same cycle it asks.
    always_comb begin
        gnt = 3'b000;
        if (!rst) begin
`ifdef SRAM_ARB_RR_EN
            case (last_q)
                PORT_SD: begin
                    if (req[1])      gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                end
                PORT_WB: begin
                    if (req[2])      gnt = 3'b100;
                    else if (req[0]) gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                end
                default: begin
                    if (req[0])      gnt = 3'b001;
                    else if (req[1]) gnt = 3'b010;
                    else if (req[2]) gnt = 3'b100;
                end
            endcase
`else
            if (req[0])      gnt = 3'b001;
            else if (req[2]) gnt = 3'b100;
            else if (req[1]) gnt = 3'b010;
`endif
        end
    end

    assign xfer = |gnt;

    always_comb begin
        gnt_idx = PORT_SD;
        if (gnt[2])      gnt_idx = PORT_RD;
        else if (gnt[1]) gnt_idx = PORT_WB;
    end

    // Non-enable command fields hold between commands; only enable drops on idle cycles.
    always_comb begin
        last_d    = last_q;
        enable_d  = xfer;
        mode_d    = mode_q;
        calc_d    = calc_q;
        addr_d    = addr_q;
        sd_data_d = sd_data_q;
        wb_data_d = wb_data_q;
        rd_pipe_d = {rd_pipe_q[0], gnt[2]};
        if (xfer) begin
            last_d = gnt_idx;
        end
        if (gnt[0]) begin
            mode_d    = 1'b0;
            calc_d    = 1'b1;
            addr_d    = sd_addr;
            sd_data_d = sd_data;
        end
        if (gnt[1]) begin
            mode_d    = 1'b0;
            calc_d    = 1'b0;
            addr_d    = wb_addr;
            wb_data_d = wb_data;
        end
        if (gnt[2]) begin
            mode_d = 1'b1;
            calc_d = 1'b0;
            addr_d = rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q    <= PORT_RD;
            enable_q  <= 1'b0;
            mode_q    <= 1'b0;
            calc_q    <= 1'b0;
            addr_q    <= '0;
            sd_data_q <= '0;
            wb_data_q <= '0;
            rd_pipe_q <= 2'b00;
        end else begin
            last_q    <= last_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            calc_q    <= calc_d;
            addr_q    <= addr_d;
            sd_data_q <= sd_data_d;
            wb_data_q <= wb_data_d;
            rd_pipe_q <= rd_pipe_d;
        end
    end

    assign sd_gnt              = gnt[0];
    assign wb_gnt              = gnt[1];
    assign rd_gnt              = gnt[2];

    assign sram_enable         = enable_q;
    assign sram_mode           = mode_q;
    assign sram_addr_calc_mode = calc_q;
    assign sram_address        = addr_q;
    assign sram_sdram_data     = sd_data_q;
    assign sram_wb_data        = wb_data_q;

    // The SRAM's own valid flag is sticky across a following write, so validity comes from our pipeline.
    assign rd_valid            = rd_pipe_q[1];
    assign rd_data             = sram_out_data;
    assign busy                = enable_q | (|rd_pipe_q);

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Three-port arbiter and sequencer in front of `sram_simulation`. It shares the single SRAM between the SDRAM row-cache writer, the window-buffer output writer and the row-cache reader. It also drives the SRAM's `enable` / `mode` / `addrCalcMode` controls, and generates its own read-valid strobe from issued reads. The SRAM's `dataReadValid` is not used because it stays high after a read when the next command is a write.

## Interface
- `ADDR_W`, default 26: SRAM word address width.
- `DATA_W`, default 32: data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `sd_req`  in  1  SDRAM-buffer write request (port 0).
- `sd_addr`  in  ADDR_W  port 0 write address.
- `sd_data`  in  DATA_W  port 0 write data.
- `sd_gnt`  out  1  port 0 grant (ready).
- `wb_req`  in  1  window-buffer write request (port 1).
- `wb_addr`  in  ADDR_W  port 1 write address.
- `wb_data`  in  DATA_W  port 1 write data.
- `wb_gnt`  out  1  port 1 grant.
- `rd_req`  in  1  read request (port 2).
- `rd_addr`  in  ADDR_W  read address.
- `rd_gnt`  out  1  port 2 grant.
- `rd_valid`  out  1  read data valid, one-cycle pulse per read.
- `rd_data`  out  DATA_W  read data, meaningful only when `rd_valid`=1.
- `sram_enable`  out  1  to SRAM `enable`.
- `sram_mode`  out  1  to SRAM `mode`: 1 = read, 0 = write.
- `sram_addr_calc_mode`  out  1  to SRAM `addrCalcMode`: 1 = SDRAM data, 0 = WB data.
- `sram_address`  out  ADDR_W  to SRAM `address`.
- `sram_sdram_data`  out  DATA_W  to SRAM `sdram_data`.
- `sram_wb_data`  out  DATA_W  to SRAM `wb_data`.
- `sram_out_data`  in  DATA_W  from SRAM `out_data`.
- `busy`  out  1  high while a command or read result is in flight.

## Operation
- **Handshake.** Each port uses valid/ready semantics.
  - Requester holds `*_req`, address and data stable until a cycle with `*_req`=1 and `*_gnt`=1 (a transfer).
  - `*_gnt` is combinational from the current `*_req` values and arbiter state.
  - At most one `*_gnt` is high per cycle, and only for a port whose req is high.
- **Command register.** On a transfer, the next edge registers `sram_enable`=1, `sram_mode`, `sram_addr_calc_mode` and `sram_address`.
  - Port 0: mode=0, calc=1, `sram_sdram_data`=`sd_data`.
  - Port 1: mode=0, calc=0, `sram_wb_data`=`wb_data`.
  - Port 2: mode=1, calc=0.
  - No transfer: `sram_enable`=0 next cycle. Other command fields hold their last values.
- **Read pipeline.** A 2-stage flag pipeline tracks issued reads.
  - `rd_valid` goes high for exactly one cycle per read transfer.
  - `rd_data` = `sram_out_data` (passthrough) during that cycle.
  - Read results cannot be stalled; the consumer must accept them.
- **Ordering.** Commands reach the SRAM in transfer order. A read transferred after a write to the same address returns the new data.
- **`busy`.** High when `sram_enable`=1 or a read flag is pending in the pipeline.
- **Arbitration FSM.** Pointer `last` ∈ {0,1,2}.
  - `last` updates to the granted index on each transfer only.
  - Idle cycles leave `last` unchanged.

## Timing
- Transfer in cycle N → `sram_enable`=1 in cycle N+1 → SRAM samples at the end of N+1 → for a read, `rd_valid`=1 in cycle N+2.
- Back-to-back transfers, one per cycle, are sustained indefinitely. Mixed read/write streams never insert bubbles.
- **Reset values:** all `*_gnt`=0 while `rst`=1. `sram_enable`=0, `sram_mode`=0, `sram_addr_calc_mode`=0, `sram_address`=0, both data outputs 0, `rd_valid`=0, `busy`=0, read pipeline cleared, `last`=2 (so port 0 has first priority).
- **Reset mid-operation:** any in-flight read is dropped, and no `rd_valid` appears after reset deasserts. An SRAM command already registered before `rst` is not recalled.
- **Simultaneous requests:** resolved in the same cycle per the configured policy. A losing requester waits with req held; its req is never lost.
- A requester that drops req before being granted is allowed, and no transfer occurs for it.

## Configuration
- **`SRAM_ARB_RR_EN` defined:** round-robin. Search order starts at (`last`+1) mod 3. No port waits more than 2 transfers while its req is held.
- **`SRAM_ARB_RR_EN` undefined:** fixed priority, port 0 > port 2 > port 1. `last` is still maintained but ignored, and starvation of lower ports is permitted.

## Test plan
- **Reset.** Assert `rst` with all reqs=1 → all gnts=0 and all SRAM outputs 0. First cycle after reset → `sd_gnt`=1.
- **Single write then read.** `wb_req` with addr 0x10, data 0xDEADBEEF transfers in cycle N → `sram_enable`=1, mode=0, calc=0 in N+1. Read of 0x10 transferred in N+1 → `rd_valid`=1 with `rd_data`=0xDEADBEEF in N+3.
- **All three requesting continuously (RR).** Grants rotate 0,2... exactly 0,1,2,0,1,2 (first-priority start at port 0). Each port gets 1/3 of the cycles, with `sram_enable` held high throughout.
- **Read after write with no bubble.** `sd_req` (addr 5, 0x1234) transfers at N, read of addr 5 at N+1 → `rd_data`=0x1234 at N+3. No `rd_valid` at N+2, because the write does not produce one.
- **Reset mid-read.** Read transferred at N, `rst`=1 in N+1 → `rd_valid` stays 0 through N+4.
- **Fixed priority (macro undefined).** `sd_req` and `wb_req` held for 4 cycles → `sd_gnt` every cycle, `wb_gnt` never. After `sd_req` drops → `wb_gnt`=1 the same cycle.
